tex_mem_arbiter: RTL and testbench

Round-robin arbiter that shares the single synchronous-read packed-ASCII transform ROM between two character fetchers: requester 0 (LHS expression) and requester 1 (RHS Laplace expression). It sits between the transformer fetch logic and the `memory` instance. It owns the ROM address register and tracks in-flight reads so each returned word is tagged back to the requester that issued it. It sustains one grant per cycle at a fixed 2-cycle read latency.

---
 rtl/tex_mem_arbiter.sv | 133 +++++++++++++
 tb/tb_tex_mem_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tex_mem_arbiter.sv
// ============================================================================
// Module   : tex_mem_arbiter
// Brief    : Round-robin arbiter sharing one synchronous-read transform ROM
//            between two fetchers, with a 2-stage return-tag pipeline.
//            Optional ownership lock enabled by defining TEX_ARB_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tex_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              vld0,
    output logic              vld1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
`ifdef TEX_ARB_LOCK_EN
    ,
    input  logic              lock0,
    input  logic              lock1
`endif
);

    logic              r_last;
    logic              r_s1_valid;
    logic              r_s1_id;
    logic              r_s2_valid;
    logic              r_s2_id;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              w_allow0;
    logic              w_allow1;
    logic              w_win0;
    logic              w_win1;
    logic              w_gnt0;
    logic              w_gnt1;

`ifdef TEX_ARB_LOCK_EN
    localparam logic [1:0] c_FREE = 2'd0;
    localparam logic [1:0] c_OWN0 = 2'd1;
    localparam logic [1:0] c_OWN1 = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       w_held;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_FREE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // An owner whose lock has dropped is arbitrated under free rules this cycle.
    always_comb begin
        w_allow0    = 1'b1;
        w_allow1    = 1'b1;
        w_held      = 1'b0;
        w_state_nxt = c_FREE;
        case (r_state)
            c_OWN0: if (lock0) begin
                w_allow1 = 1'b0;
                w_held   = 1'b1;
            end
            c_OWN1: if (lock1) begin
                w_allow0 = 1'b0;
                w_held   = 1'b1;
            end
            default: ;
        endcase
        if (w_held) begin
            w_state_nxt = r_state;
        end else if (w_gnt0 && lock0) begin
            w_state_nxt = c_OWN0;
        end else if (w_gnt1 && lock1) begin
            w_state_nxt = c_OWN1;
        end
    end
`else
    assign w_allow0 = 1'b1;
    assign w_allow1 = 1'b1;
`endif

    // On a tie the requester that was not granted last wins.
    always_comb begin
        w_win0 = req0 & w_allow0;
        w_win1 = req1 & w_allow1;
        w_gnt0 = w_win0 & (~w_win1 | r_last);
        w_gnt1 = w_win1 & (~w_win0 | ~r_last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last     <= 1'b1;
            r_mem_addr <= '0;
            r_s1_valid <= 1'b0;
            r_s1_id    <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_id    <= 1'b0;
        end else begin
            if (w_gnt0 || w_gnt1) begin
                r_mem_addr <= w_gnt1 ? addr1 : addr0;
                r_last     <= w_gnt1;
            end
            r_s1_valid <= w_gnt0 | w_gnt1;
            r_s1_id    <= w_gnt1;
            r_s2_valid <= r_s1_valid;
            r_s2_id    <= r_s1_id;
        end
    end

    assign gnt0     = w_gnt0;
    assign gnt1     = w_gnt1;
    assign mem_addr = r_mem_addr;
    assign vld0     = r_s2_valid & ~r_s2_id;
    assign vld1     = r_s2_valid & r_s2_id;
    assign rdata    = r_s2_valid ? mem_dout : '0;
    assign busy     = r_s1_valid | r_s2_valid;

endmodule

`default_nettype wire

// File: tb/tb_tex_mem_arbiter.sv
// ============================================================================
// Module   : tb_tex_mem_arbiter
// Brief    : Self-checking bench for tex_mem_arbiter with a behavioural ROM
//            and a queue-based model of grants and returns.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tex_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [7:0]  addr0 = '0;
    logic [7:0]  addr1 = '0;
    logic        lock0 = 1'b0;
    logic        lock1 = 1'b0;
    logic        gnt0, gnt1, vld0, vld1, busy;
    logic [15:0] rdata;
    logic [7:0]  mem_addr;
    logic [15:0] mem_dout = '0;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int          due;
        int          id;
        logic [15:0] data;
    } ret_t;

    ret_t       q[$];
    int         cyc     = 0;
    int         m_last  = 1;
    int         m_owner = -1;
    logic [7:0] m_addr  = '0;
    int         m_g     = -1;

    tex_mem_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .addr0    (addr0),
        .addr1    (addr1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .vld0     (vld0),
        .vld1     (vld1),
        .rdata    (rdata),
        .mem_addr (mem_addr),
        .mem_dout (mem_dout),
        .busy     (busy)
`ifdef TEX_ARB_LOCK_EN
        ,
        .lock0    (lock0),
        .lock1    (lock1)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_fn(input logic [7:0] a);
        return {a ^ 8'hA5, a + 8'h31};
    endfunction

    always @(posedge clk) mem_dout <= rom_fn(mem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Who wins this cycle, from the request/lock rules alone.
    function automatic int model_grant();
        bit w0, w1;
`ifdef TEX_ARB_LOCK_EN
        if (m_owner == 0 && !lock0) m_owner = -1;
        if (m_owner == 1 && !lock1) m_owner = -1;
        w0 = req0 && (m_owner != 1);
        w1 = req1 && (m_owner != 0);
`else
        w0 = req0;
        w1 = req1;
`endif
        if (w0 && w1) return (m_last == 0) ? 1 : 0;
        if (w0) return 0;
        if (w1) return 1;
        return -1;
    endfunction

    task automatic do_cycle();
        logic        ev;
        int          eid;
        logic [15:0] ed;
        #1;
        m_g = model_grant();
        ev  = 1'b0;
        eid = -1;
        ed  = '0;
        if (q.size() > 0) begin
            if (q[0].due == cyc) begin
                ev  = 1'b1;
                eid = q[0].id;
                ed  = q[0].data;
            end
        end
        chk("gnt0", 32'(gnt0), 32'(m_g == 0));
        chk("gnt1", 32'(gnt1), 32'(m_g == 1));
        chk("vld0", 32'(vld0), 32'(ev && eid == 0));
        chk("vld1", 32'(vld1), 32'(ev && eid == 1));
        chk("rdata", 32'(rdata), 32'(ed));
        chk("busy", 32'(busy), 32'(q.size() > 0 && q[0].due <= cyc + 1));
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        @(posedge clk);
        if (m_g >= 0) begin
            m_addr = (m_g == 1) ? addr1 : addr0;
            q.push_back('{due: cyc + 2, id: m_g, data: rom_fn(m_addr)});
            m_last = m_g;
`ifdef TEX_ARB_LOCK_EN
            if (m_owner < 0 && ((m_g == 0) ? lock0 : lock1)) m_owner = m_g;
`endif
        end
        while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
        cyc++;
        @(negedge clk);
    endtask

    // Reset is raised mid-cycle so its asynchronous effect is observed.
    task automatic do_reset();
        req0 = 1'b0;
        req1 = 1'b0;
        lock0 = 1'b0;
        lock1 = 1'b0;
        rst  = 1'b1;
        #1;
        chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        chk("rst_vld", {30'd0, vld1, vld0}, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        m_last  = 1;
        m_owner = -1;
        m_addr  = '0;
        cyc++;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // single read
        req0 = 1'b1; addr0 = 8'h05;
        do_cycle();
        req0 = 1'b0;
        repeat (3) do_cycle();

        // contention from a fresh reset
        do_reset();
        req0 = 1'b1; req1 = 1'b1; addr0 = 8'h10; addr1 = 8'h20;
        repeat (6) do_cycle();
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) do_cycle();

        // idle hold
        req1 = 1'b1; addr1 = 8'h3F;
        do_cycle();
        req1 = 1'b0;
        repeat (4) do_cycle();

        // reset with a read in flight, then first tie after reset
        req0 = 1'b1; addr0 = 8'h44;
        do_cycle();
        do_reset();
        repeat (3) do_cycle();
        req0 = 1'b1; req1 = 1'b1; addr0 = 8'h01; addr1 = 8'h02;
        do_cycle();
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) do_cycle();

        // lock sequence (alternates when the lock feature is absent)
        do_reset();
        req0 = 1'b1; lock0 = 1'b1; req1 = 1'b1; addr0 = 8'h11; addr1 = 8'h22;
        repeat (4) do_cycle();
        lock0 = 1'b0;
        do_cycle();
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) do_cycle();

        // randomized traffic, requests held until granted
        for (int i = 0; i < 400; i++) begin
            if (!req0 || m_g == 0 || $urandom_range(7) == 0) begin
                req0  = ($urandom_range(2) != 0);
                addr0 = 8'($urandom);
            end
            if (!req1 || m_g == 1 || $urandom_range(7) == 0) begin
                req1  = ($urandom_range(2) != 0);
                addr1 = 8'($urandom);
            end
            lock0 = ($urandom_range(3) == 0);
            lock1 = ($urandom_range(3) == 0);
            if ($urandom_range(63) == 0) begin
                do_reset();
                m_g = -1;
            end else begin
                do_cycle();
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) do_cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
